pc_sequencer: RTL and testbench

Multi-cycle control FSM for the program counter datapath. It sequences each instruction through fetch and execute against an instruction memory with a ready handshake. It issues exactly one PC-update strobe per retired instruction, with a next-PC source select, and stops the machine on a halt instruction, a PC limit overrun or a fetch timeout. It sits between the top-level core control, the instruction memory port and the PC register/next-PC mux, and keeps cycle and retired-instruction counters for the bench.

---
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the PC datapath: one PC write strobe per retired
// instruction, next-PC source select, and sticky halt/error stop states.
module pc_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int PC_LIMIT = 100,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_value,
    input  logic              imem_ready,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [1:0]        jump,
    input  logic              halt_instr,
    output logic              imem_req,
    output logic              pc_en,
    output logic [1:0]        pc_sel,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q;
    logic [7:0]       wait_q;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             at_limit;
    logic             in_exec_go;

    // Zero-extend before comparing so a limit wider than the PC still works.
    assign at_limit   = (32'(pc_value) >= 32'(PC_LIMIT));
    assign in_exec_go = (state_q == S_EXEC) && !stall;

    assign imem_req = (state_q == S_FETCH);
    assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted   = (state_q == S_HALT);
    assign error    = (state_q == S_ERROR);
    assign pc_en    = in_exec_go && !halt_instr && !at_limit;

    always_comb begin
        pc_sel = 2'b00;
        if (pc_en) begin
            if (branch_taken)      pc_sel = 2'b01;
            else if (jump == 2'b11) pc_sel = 2'b10;
            else if (jump == 2'b01) pc_sel = 2'b11;
            else                    pc_sel = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        state_q <= S_EXEC;
                        wait_q  <= 8'd0;
                    end else if (wait_q == TIMEOUT_C) begin
                        state_q <= S_ERROR;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (in_exec_go) begin
                        state_q <= (halt_instr || at_limit) ? S_HALT : S_FETCH;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                S_ERROR: state_q <= S_ERROR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Both counters saturate rather than wrap.
    assign cycle_d = (busy && cycle_q != CNT_MAX) ? cycle_q + CNT_W'(1) : cycle_q;
    assign instr_d = (pc_en && instr_q != CNT_MAX) ? instr_q + CNT_W'(1) : instr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_sequencer;

    localparam int ADDR_W = 8;
    localparam int LIMIT  = 100;
    localparam int TO     = 15;
    localparam int CW     = 6;
    localparam int CMAX   = (1 << CW) - 1;

    // Model phases (bench-local labels, not the RTL encoding).
    localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3, P_ERR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] pc_value;
    logic              imem_ready;
    logic              stall;
    logic              branch_taken;
    logic [1:0]        jump;
    logic              halt_instr;
    logic              imem_req;
    logic              pc_en;
    logic [1:0]        pc_sel;
    logic              busy;
    logic              halted;
    logic              error;
    logic [CW-1:0]     cycle_count;
    logic [CW-1:0]     instr_count;

    int checks = 0;
    int errors = 0;

    int m_ph, m_miss, m_cyc, m_ins;

    pc_sequencer #(
        .ADDR_W(ADDR_W), .PC_LIMIT(LIMIT), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc_value(pc_value),
        .imem_ready(imem_ready), .stall(stall), .branch_taken(branch_taken),
        .jump(jump), .halt_instr(halt_instr), .imem_req(imem_req),
        .pc_en(pc_en), .pc_sel(pc_sel), .busy(busy), .halted(halted),
        .error(error), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; pc_value = '0; imem_ready = 0; stall = 0;
        branch_taken = 0; jump = 2'b00; halt_instr = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1;
        clear_inputs();
        cyc();
        rst = 0;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    always @(negedge clk) begin
        int e_sel;
        bit retire;
        if (rst) begin
            m_ph = P_IDLE; m_miss = 0; m_cyc = 0; m_ins = 0;
        end
        retire = !rst && m_ph == P_EXEC && !stall && !halt_instr && int'(pc_value) < LIMIT;
        if (!retire)                  e_sel = 0;
        else if (branch_taken)        e_sel = 1;
        else if (jump == 2'b11)       e_sel = 2;
        else if (jump == 2'b01)       e_sel = 3;
        else                          e_sel = 0;

        chk("imem_req",    imem_req,    m_ph == P_FETCH);
        chk("busy",        busy,        m_ph == P_FETCH || m_ph == P_EXEC);
        chk("halted",      halted,      m_ph == P_HALT);
        chk("error",       error,       m_ph == P_ERR);
        chk("pc_en",       pc_en,       retire);
        chk("pc_sel",      pc_sel,      e_sel);
        chk("cycle_count", cycle_count, m_cyc);
        chk("instr_count", instr_count, m_ins);

        if (!rst) begin
            if (m_ph == P_FETCH || m_ph == P_EXEC) m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
            if (retire) m_ins = (m_ins < CMAX) ? m_ins + 1 : CMAX;
            case (m_ph)
                P_IDLE:  if (start) m_ph = P_FETCH;
                P_FETCH: begin
                    // Error after TIMEOUT+1 consecutive misses.
                    if (imem_ready) begin
                        m_miss = 0; m_ph = P_EXEC;
                    end else begin
                        m_miss++;
                        if (m_miss == TO + 1) m_ph = P_ERR;
                    end
                end
                P_EXEC: begin
                    if (!stall) m_ph = (halt_instr || int'(pc_value) >= LIMIT) ? P_HALT : P_FETCH;
                end
                default: ;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        logic [1:0] br_tab [4];
        logic [1:0] jp_tab [4];
        int         sel_tab[4];
        br_tab  = '{2'd1, 2'd0, 2'd0, 2'd0};
        jp_tab  = '{2'b11, 2'b11, 2'b01, 2'b10};
        sel_tab = '{1, 2, 3, 0};

        rst = 1;
        clear_inputs();
        repeat (2) cyc();
        chk("reset_busy", busy, 0);
        chk("reset_cnt", cycle_count, 0);
        rst = 0;
        cyc();

        // Straight-line: pc_en every second cycle, sequential select.
        do_reset();
        start = 1; imem_ready = 1;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("sl_pc_en", pc_en, (i % 2) == 0);
            chk("sl_pc_sel", pc_sel, 0);
            pulses += int'(pc_en);
            pc_value = pc_value + (pc_en ? 8'd4 : 8'd0);
        end
        cyc();
        chk("sl_pulses", pulses, 5);
        chk("sl_instr", instr_count, 5);
        chk("sl_cycles", cycle_count, 10);

        // Next-PC select priority.
        do_reset();
        start = 1; imem_ready = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            branch_taken = br_tab[k][0]; jump = jp_tab[k];
            cyc();
            #1;
            chk("prio_pc_en", pc_en, 1);
            chk("prio_pc_sel", pc_sel, sel_tab[k]);
        end

        // Memory wait plus stall: 7-cycle instruction.
        do_reset();
        start = 1; branch_taken = 0; jump = 0;
        repeat (3) cyc();
        cyc(); imem_ready = 1;
        cyc(); stall = 1;
        cyc();
        #1 chk("ws_stall_no_en", pc_en, 0);
        cyc(); stall = 0;
        #1 chk("ws_en", pc_en, 1);
        cyc();
        chk("ws_cycles", cycle_count, 7);
        chk("ws_instr", instr_count, 1);
        chk("ws_refetch", imem_req, 1);

        // Halt instruction, then start toggling is ignored.
        do_reset();
        start = 1; imem_ready = 1;
        cyc();
        cyc(); halt_instr = 1;
        #1 chk("h_no_en", pc_en, 0);
        cyc(); halt_instr = 0;
        chk("h_halted", halted, 1);
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            cyc();
            chk("h_sticky", halted, 1);
            chk("h_busy", busy, 0);
        end
        chk("h_instr", instr_count, 0);

        // PC limit boundary: 99 retires, 100 halts.
        do_reset();
        start = 1; imem_ready = 1;
        cyc();
        cyc(); pc_value = 8'd99;
        #1 chk("lim99_en", pc_en, 1);
        cyc();
        cyc(); pc_value = 8'd100;
        #1 chk("lim100_en", pc_en, 0);
        cyc();
        chk("lim_halted", halted, 1);

        // Fetch timeout.
        do_reset();
        pc_value = 0; start = 1; imem_ready = 0;
        for (int i = 1; i <= TO + 1; i++) begin
            cyc();
            chk("to_req", imem_req, 1);
            chk("to_err_early", error, 0);
        end
        cyc();
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        chk("to_req_off", imem_req, 0);
        chk("to_cycles", cycle_count, TO + 1);
        imem_ready = 1;
        repeat (3) cyc();
        chk("to_late_ready", error, 1);

        // Asynchronous reset mid-EXEC with pc_en about to fire.
        do_reset();
        start = 1; imem_ready = 1;
        cyc();
        cyc();
        #1 chk("ar_pre_en", pc_en, 1);
        #1 rst = 1;
        #1;
        chk("ar_pc_en", pc_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_req", imem_req, 0);
        chk("ar_cycles", cycle_count, 0);
        chk("ar_instr", instr_count, 0);
        start = 0;
        cyc();
        rst = 0;
        cyc();
        chk("ar_idle", busy, 0);
        chk("ar_no_update", instr_count, 0);

        // Randomized traffic; model checks every cycle.
        for (int seg = 0; seg < 24; seg++) begin
            do_reset();
            for (int c = 0; c < 90; c++) begin
                cyc();
                start        = ($urandom_range(0, 3) != 0);
                imem_ready   = (seg % 6 == 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
                stall        = ($urandom_range(0, 3) == 0);
                branch_taken = ($urandom_range(0, 2) == 0);
                jump         = 2'($urandom_range(0, 3));
                halt_instr   = ($urandom_range(0, 29) == 0);
                pc_value     = ($urandom_range(0, 24) == 0) ? 8'($urandom_range(100, 255))
                                                            : 8'($urandom_range(0, 99));
                if ($urandom_range(0, 79) == 0) begin
                    #2 rst = 1;
                    cyc();
                    rst = 0;
                end
            end
        end

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
